// File: rtl/ppu_vram_arbiter.sv
// PPU VRAM arbiter: the renderer always owns VRAM, and a single pending CPU PPUDATA access runs in the idle gaps.
// Optional PPU_READ_BUFFER_EN enables the PPUDATA read buffer (delayed reads below the palette range).
module ppu_vram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        render_active,
    input  logic [15:0] render_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_drop,
    output logic [15:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        vram_we,
    input  logic [7:0]  vram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        CPU_ADDR,
        CPU_DATA
    } state_t;

    state_t      state_q, state_d;
    logic        pend_vld_q, pend_vld_d;
    logic        pend_we_q, pend_we_d;
    logic [15:0] pend_addr_q, pend_addr_d;
    logic [7:0]  pend_wdata_q, pend_wdata_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic        cpu_drop_q, cpu_drop_d;
    logic        accept;
    logic [7:0]  rd_result;
`ifdef PPU_READ_BUFFER_EN
    logic [7:0]  rbuf_q, rbuf_d;
`endif

    always_comb begin
        state_d      = state_q;
        pend_vld_d   = pend_vld_q;
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_drop_d   = cpu_drop_q;
        cpu_ack      = 1'b0;
        vram_we      = 1'b0;
`ifdef PPU_READ_BUFFER_EN
        rbuf_d       = rbuf_q;
        rd_result    = (pend_addr_q < 16'h3F00) ? rbuf_q : vram_rdata;
`else
        rd_result    = vram_rdata;
`endif

        // Busy drops in the ack cycle so a back-to-back request can be taken.
        cpu_busy = pend_vld_q && (state_q != CPU_DATA);
        accept   = cpu_req && !cpu_busy;

        case (state_q)
            IDLE: begin
                if (pend_vld_q && !render_active) state_d = CPU_ADDR;
            end
            CPU_ADDR: begin
                if (render_active) begin
                    state_d = IDLE;
                end else begin
                    vram_we = pend_we_q;
                    state_d = CPU_DATA;
                end
            end
            CPU_DATA: begin
                cpu_ack    = 1'b1;
                pend_vld_d = 1'b0;
                if (!pend_we_q) begin
                    cpu_rdata_d = rd_result;
`ifdef PPU_READ_BUFFER_EN
                    rbuf_d      = vram_rdata;
`endif
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            pend_vld_d   = 1'b1;
            pend_we_d    = cpu_we;
            pend_addr_d  = cpu_addr;
            pend_wdata_d = cpu_wdata;
        end
        if (cpu_req && cpu_busy) cpu_drop_d = 1'b1;

        cpu_rdata  = cpu_rdata_d;
        cpu_drop   = cpu_drop_q;
        vram_addr  = render_active ? render_addr : pend_addr_q;
        vram_wdata = pend_wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_vld_q  <= 1'b0;
            cpu_rdata_q <= 8'h00;
            cpu_drop_q  <= 1'b0;
`ifdef PPU_READ_BUFFER_EN
            rbuf_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_drop_q  <= cpu_drop_d;
`ifdef PPU_READ_BUFFER_EN
            rbuf_q      <= rbuf_d;
`endif
        end
    end

    // Request payload is only meaningful while pend_vld_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        pend_we_q    <= pend_we_d;
        pend_addr_q  <= pend_addr_d;
        pend_wdata_q <= pend_wdata_d;
    end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter with a behavioural VRAM (one-cycle read latency).
module tb_ppu_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        render_active = 1'b0;
    logic [15:0] render_addr = 16'h0000;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_busy, cpu_ack, cpu_drop, vram_we;
    logic [7:0]  cpu_rdata, vram_wdata;
    logic [7:0]  vram_rdata = 8'h00;
    logic [15:0] vram_addr;

    bit [7:0] mem [0:65535];

    int checks = 0;
    int fails  = 0;

    ppu_vram_arbiter dut (
        .clk(clk), .reset(reset),
        .render_active(render_active), .render_addr(render_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_drop(cpu_drop),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_rdata(vram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [15:0] a, input logic [7:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    // Issues one request and returns cycles-to-ack (3 is minimum; -1 on timeout).
    task automatic run_req(input logic we, input logic [15:0] a, input logic [7:0] d,
                           output int lat, output int wecnt, output logic [7:0] rd);
        issue(we, a, d);
        wecnt = 0;
        tick;
        cpu_req = 1'b0;
        lat = 1;
        while (!cpu_ack && lat < 60) begin
            if (vram_we) wecnt++;
            tick;
            lat++;
        end
        rd = cpu_rdata;
        if (!cpu_ack) lat = -1;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wecnt, n, acks, bad_addr, bad_we, bad_busy;
        logic [7:0] rd;

        tick;
        tick;
        chk("rst_busy", cpu_busy, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_rdata", cpu_rdata, 8'h00);
        chk("rst_drop", cpu_drop, 0);
        chk("rst_we", vram_we, 0);
        reset = 1'b0;
        tick;

        // Write with render idle, cycle by cycle
        issue(1'b1, 16'h2005, 8'hA7);
        chk("wr_c0_busy", cpu_busy, 0);
        tick;
        cpu_req = 1'b0;
        chk("wr_c1_busy", cpu_busy, 1);
        chk("wr_c1_we", vram_we, 0);
        tick;
        chk("wr_c2_we", vram_we, 1);
        chk("wr_c2_addr", vram_addr, 16'h2005);
        chk("wr_c2_wdata", vram_wdata, 8'hA7);
        chk("wr_c2_ack", cpu_ack, 0);
        tick;
        chk("wr_c3_ack", cpu_ack, 1);
        chk("wr_c3_we", vram_we, 0);
        chk("wr_c3_busy", cpu_busy, 0);
        tick;
        chk("wr_c4_ack", cpu_ack, 0);
        chk("wr_mem_2005", mem[16'h2005], 8'hA7);

        // Plain read
        run_req(1'b1, 16'h2400, 8'h3C, lat, wecnt, rd);
        chk("wr2400_lat", lat, 3);
        chk("wr2400_wecnt", wecnt, 1);
        run_req(1'b0, 16'h2400, 8'h00, lat, wecnt, rd);
        chk("rd2400_lat", lat, 3);
        chk("rd2400_wecnt", wecnt, 0);
`ifndef PPU_READ_BUFFER_EN
        chk("rd2400_data", rd, 8'h3C);
        chk("rd2400_hold", cpu_rdata, 8'h3C);
`endif
        run_req(1'b1, 16'h2500, 8'h55, lat, wecnt, rd);
        chk("wr2500_lat", lat, 3);
        chk("wr_keeps_rdata", cpu_rdata, rd);

        // Request in the ack cycle is accepted
        issue(1'b0, 16'h2005, 8'h00);
        tick;
        cpu_req = 1'b0;
        tick;
        tick;
        chk("b2b_ack1", cpu_ack, 1);
        chk("b2b_busy1", cpu_busy, 0);
`ifndef PPU_READ_BUFFER_EN
        chk("b2b_rd1", cpu_rdata, 8'hA7);
`endif
        issue(1'b0, 16'h2400, 8'h00);
        tick;
        cpu_req = 1'b0;
        chk("b2b_busy2", cpu_busy, 1);
        chk("b2b_nodrop", cpu_drop, 0);
        tick;
        tick;
        chk("b2b_ack2", cpu_ack, 1);
`ifndef PPU_READ_BUFFER_EN
        chk("b2b_rd2", cpu_rdata, 8'h3C);
`endif
        tick;

        // Renderer holds VRAM for 40 cycles while a write is pending
        render_active = 1'b1;
        render_addr   = 16'h0100;
        issue(1'b1, 16'h2100, 8'h5A);
        tick;
        cpu_req = 1'b0;
        bad_addr = 0; bad_we = 0; bad_busy = 0; acks = 0;
        for (int i = 0; i < 40; i++) begin
            render_addr = 16'h0100 + 16'(i);
            #1;
            if (vram_addr !== render_addr) bad_addr++;
            if (vram_we !== 1'b0) bad_we++;
            if (cpu_busy !== 1'b1) bad_busy++;
            if (cpu_ack) acks++;
            tick;
        end
        chk("hold_addr_track", bad_addr, 0);
        chk("hold_no_we", bad_we, 0);
        chk("hold_busy", bad_busy, 0);
        chk("hold_no_ack", acks, 0);
        render_active = 1'b0;
        n = 1; wecnt = 0;
        while (!cpu_ack && n < 60) begin
            if (vram_we) wecnt++;
            tick;
            n++;
        end
        chk("hold_release_lat", n, 3);
        chk("hold_release_we", wecnt, 1);
        tick;
        chk("hold_mem_2100", mem[16'h2100], 8'h5A);

        // Renderer steals the CPU_ADDR slot; a second request is dropped
        issue(1'b1, 16'h2200, 8'h77);
        tick;
        cpu_req = 1'b0;
        tick;
        render_active = 1'b1;
        render_addr   = 16'h0ABC;
        issue(1'b1, 16'h2300, 8'h99);
        #1;
        chk("abort_we", vram_we, 0);
        chk("abort_addr", vram_addr, 16'h0ABC);
        tick;
        cpu_req = 1'b0;
        chk("abort_drop", cpu_drop, 1);
        chk("abort_busy", cpu_busy, 1);
        acks = 0; bad_we = 0;
        for (int i = 0; i < 5; i++) begin
            if (cpu_ack) acks++;
            if (vram_we) bad_we++;
            tick;
        end
        chk("abort_no_ack", acks, 0);
        chk("abort_no_we", bad_we, 0);
        render_active = 1'b0;
        n = 1;
        while (!cpu_ack && n < 60) begin
            tick;
            n++;
        end
        chk("retry_lat", n, 3);
        tick;
        chk("retry_mem_2200", mem[16'h2200], 8'h77);
        chk("dropped_mem_2300", mem[16'h2300], 8'h00);
        chk("drop_sticky", cpu_drop, 1);

        // Reset while in CPU_DATA
        issue(1'b0, 16'h2005, 8'h00);
        tick;
        cpu_req = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        chk("rstd_ack", cpu_ack, 0);
        chk("rstd_busy", cpu_busy, 0);
        chk("rstd_drop", cpu_drop, 0);
        chk("rstd_rdata", cpu_rdata, 8'h00);
        chk("rstd_we", vram_we, 0);
        tick;
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            if (cpu_ack) acks++;
            tick;
        end
        chk("rstd_no_ack", acks, 0);

`ifdef PPU_READ_BUFFER_EN
        run_req(1'b1, 16'h2000, 8'h11, lat, wecnt, rd);
        run_req(1'b1, 16'h2001, 8'h22, lat, wecnt, rd);
        run_req(1'b1, 16'h3F01, 8'h0F, lat, wecnt, rd);
        run_req(1'b0, 16'h2000, 8'h00, lat, wecnt, rd);
        chk("buf_rd_2000", rd, 8'h00);
        run_req(1'b0, 16'h2001, 8'h00, lat, wecnt, rd);
        chk("buf_rd_2001", rd, 8'h11);
        run_req(1'b0, 16'h3F01, 8'h00, lat, wecnt, rd);
        chk("buf_rd_3f01", rd, 8'h0F);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
